// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares the single 32-bit video memory port (4 planes x 8 bits)
// between the framebuffer's periodic fetch and CPU byte accesses. Video has
// priority and a fetch deadline; the CPU is served in the gaps via req/ack.
//
// Ports:
//   clk24, reset_n          24 MHz clock, asynchronous active-low reset
//   vid_req, vid_addr       fetch request pulse and word address
//   vid_data, vid_miss      last fetched word (registered), deadline/lost-fetch pulse
//   cpu_req, cpu_we, cpu_addr, cpu_plane, cpu_wdata
//                           CPU byte access (level request, inputs stable until ack)
//   cpu_rdata, cpu_ack      read byte (registered), one-cycle completion pulse
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be
//                           memory controller request, held until mem_ack
//   mem_ack, mem_rdata      controller completion pulse and read data
//   miss_count              saturating vid_miss counter
//
// Optional feature: define VMEM_ARB_MISS_COUNT_EN to build the miss counter;
// otherwise miss_count is tied to zero.
module vmem_arbiter #(
  parameter int unsigned VID_DEADLINE = 48,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk24,
  input  logic             reset_n,
  input  logic             vid_req,
  input  logic [15:0]      vid_addr,
  output logic [31:0]      vid_data,
  output logic             vid_miss,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_addr,
  input  logic [1:0]       cpu_plane,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned DW = $clog2(VID_DEADLINE + 1);
  localparam logic [DW-1:0] DL_MAX = DW'(VID_DEADLINE);
  localparam logic [DW-1:0] DL_PRE = DW'(VID_DEADLINE - 1);

  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  state_t        state, state_nx;
  logic          vid_pend;
  logic [15:0]   vid_addr_q;
  logic [15:0]   fetch_addr;
  logic [DW-1:0] dcnt;
  logic          cpu_hold;
  logic          vid_done, cpu_done, count_en, dl_hit, overwrite;

  assign vid_done  = (state == VID) && mem_ack;
  assign cpu_done  = (state == CPU) && mem_ack;
  assign count_en  = vid_pend || (state == VID);
  // A request arriving this cycle restarts the counter, so it cannot also expire.
  assign dl_hit    = count_en && !vid_req && (dcnt == DL_PRE);
  assign overwrite = vid_req && vid_pend && (state != VID);

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // A vid_req in the same cycle counts as pending so video wins a tie with the CPU.
  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state)
      IDLE: begin
        if (vid_pend || vid_req)        state_nx = VID;
        else if (cpu_req && !cpu_hold)  state_nx = CPU;
      end
      VID: begin
        mem_req  = 1'b1;
        mem_addr = fetch_addr;
        mem_be   = '1;
        if (mem_ack) state_nx = IDLE;
      end
      CPU: begin
        mem_req   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_be    = 4'b0001 << cpu_plane;
        mem_wdata = {4{cpu_wdata}};
        if (mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // fetch_addr freezes the issued address so a later vid_req cannot disturb
  // mem_addr while the fetch is outstanding.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      vid_pend   <= 1'b0;
      vid_addr_q <= '0;
      fetch_addr <= '0;
      dcnt       <= '0;
      vid_data   <= '0;
      vid_miss   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
        dcnt       <= '0;
      end else begin
        if (vid_done)                     vid_pend <= 1'b0;
        if (count_en && (dcnt != DL_MAX)) dcnt     <= dcnt + 1'b1;
      end
      if ((state == IDLE) && (state_nx == VID))
        fetch_addr <= vid_req ? vid_addr : vid_addr_q;
      if (vid_done) vid_data <= mem_rdata;
      vid_miss <= dl_hit || overwrite;
      cpu_ack  <= cpu_done;
      if (cpu_done && !cpu_we) cpu_rdata <= mem_rdata[{cpu_plane, 3'b000} +: 8];
      if (cpu_done)     cpu_hold <= 1'b1;
      else if (!cpu_req) cpu_hold <= 1'b0;
    end
  end

`ifdef VMEM_ARB_MISS_COUNT_EN
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n)                         miss_count <= '0;
    else if (vid_miss && (miss_count != '1)) miss_count <= miss_count + 1'b1;
  end
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
module tb_vmem_arbiter;
  localparam int DL = 48;
  localparam int CW = 8;

  logic          clk24 = 1'b0;
  logic          reset_n;
  logic          vid_req;
  logic [15:0]   vid_addr;
  logic [31:0]   vid_data;
  logic          vid_miss;
  logic          cpu_req, cpu_we;
  logic [15:0]   cpu_addr;
  logic [1:0]    cpu_plane;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          mem_req, mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [CW-1:0] miss_count;

  int total = 0, bad = 0;
  int cyc = 0;
  int miss_seen = 0, last_miss_cyc = -1;
  int exp_pulses = 0;   // vid_miss pulses expected since start
  int exp_miss = 0;     // misses expected since last reset
  logic [7:0] exp_rdata = '0;

  vmem_arbiter #(.VID_DEADLINE(DL), .CNT_W(CW)) dut (
    .clk24(clk24), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_plane(cpu_plane),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_count(miss_count)
  );

  initial forever #5 clk24 = ~clk24;
  always @(posedge clk24) cyc <= cyc + 1;
  always @(negedge clk24)
    if (reset_n === 1'b1 && vid_miss === 1'b1) begin
      miss_seen     <= miss_seen + 1;
      last_miss_cyc <= cyc;
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk24);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_mc();
`ifdef VMEM_ARB_MISS_COUNT_EN
    return (exp_miss > 255) ? 32'd255 : 32'(exp_miss);
`else
    return 32'd0;
`endif
  endfunction

  // Controller model: waits for mem_req, checks the request fields stay put,
  // acks n cycles after mem_req was first seen high. Optionally injects a
  // vid_req on tick 'inj' of the wait.
  task automatic serve(input string tag, input logic exp_we, input logic [15:0] exp_addr,
                       input logic [3:0] exp_be, input logic chk_wd, input logic [31:0] exp_wd,
                       input int n, input logic [31:0] rd, input int inj,
                       input logic [15:0] inj_addr, output int inj_cyc);
    int k = 0;
    inj_cyc = -1;
    while (mem_req !== 1'b1 && k < 200) begin tick(); k++; end
    if (mem_req !== 1'b1) begin
      chk({tag, "_req_timeout"}, 32'(mem_req), 32'd1);
      return;
    end
    chk({tag, "_fields"}, {10'd0, mem_req, mem_we, mem_be, mem_addr}, {10'd0, 1'b1, exp_we, exp_be, exp_addr});
    if (chk_wd) chk({tag, "_wdata"}, mem_wdata, exp_wd);
    for (int i = 0; i < n; i++) begin
      if (i == inj) begin vid_addr = inj_addr; vid_req = 1'b1; inj_cyc = cyc; end
      tick();
      vid_req = 1'b0;
      chk({tag, "_stable"}, {10'd0, mem_req, mem_we, mem_be, mem_addr}, {10'd0, 1'b1, exp_we, exp_be, exp_addr});
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = $urandom;
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
  endtask

  task automatic do_vid(input string tag, input logic [15:0] addr, input int n, input logic [31:0] rd);
    int c, ic;
    vid_addr = addr; vid_req = 1'b1; c = cyc;
    tick();
    vid_req = 1'b0;
    serve(tag, 1'b0, addr, 4'hF, 1'b0, 32'd0, n, rd, -1, 16'd0, ic);
    chk({tag, "_vid_data"}, vid_data, rd);
    chk({tag, "_latency"}, 32'(cyc - c), 32'(n + 2));
    if (n + 1 >= DL) begin exp_miss++; exp_pulses++; end
  endtask

  task automatic do_cpu(input string tag, input logic we, input logic [1:0] plane,
                        input logic [15:0] addr, input logic [7:0] wd, input int n,
                        input logic [31:0] rd, input int hold);
    int ic;
    cpu_we = we; cpu_plane = plane; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    tick();
    serve(tag, we, addr, 4'(1 << plane), 1'b1, 32'(wd) * 32'h01010101, n, rd, -1, 16'd0, ic);
    chk({tag, "_ack"}, 32'(cpu_ack), 32'd1);
    if (!we) exp_rdata = 8'((rd >> (8 * plane)) & 32'hFF);
    chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_rdata));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_held_idle"}, {30'd0, cpu_ack, mem_req}, 32'd0);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    int ic, m0;
    reset_n = 1'b0; vid_req = 0; vid_addr = 0; cpu_req = 0; cpu_we = 0;
    cpu_addr = 0; cpu_plane = 0; cpu_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) tick();
    chk("rst_vid_data", vid_data, 32'd0);
    chk("rst_vid_miss", 32'(vid_miss), 32'd0);
    chk("rst_cpu", {23'd0, cpu_ack, cpu_rdata}, 32'd0);
    chk("rst_mem_ctl", {26'd0, mem_req, mem_we, mem_be}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Video only
    do_vid("vid", 16'h80A5, 3, 32'hDEADBEEF);
    repeat (2) tick();
    chk("vid_no_miss", 32'(miss_seen), 32'(exp_pulses));

    // CPU write with cpu_req held high after ack
    do_cpu("cpu_wr", 1'b1, 2'd2, 16'h1234, 8'h3C, 2, 32'h0, 5);
    // CPU read, plane 1
    do_cpu("cpu_rd", 1'b0, 2'd1, 16'h0777, 8'h00, 3, 32'h11223344, 1);
    chk("cpu_rd_byte", 32'(cpu_rdata), 32'h33);

    // Contention: both requests in the same cycle, video goes first
    cpu_we = 0; cpu_plane = 3; cpu_addr = 16'h0042; cpu_wdata = 0; cpu_req = 1'b1;
    vid_addr = 16'h0F0F; vid_req = 1'b1;
    tick();
    vid_req = 1'b0;
    serve("cont_vid", 1'b0, 16'h0F0F, 4'hF, 1'b0, 32'd0, 2, 32'hCAFEF00D, -1, 16'd0, ic);
    chk("cont_vid_data", vid_data, 32'hCAFEF00D);
    chk("cont_cpu_wait", 32'(cpu_ack), 32'd0);
    serve("cont_cpu", 1'b0, 16'h0042, 4'b1000, 1'b1, 32'd0, 2, 32'hA1B2C3D4, -1, 16'd0, ic);
    chk("cont_cpu_ack", 32'(cpu_ack), 32'd1);
    exp_rdata = 8'hA1;
    chk("cont_cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    tick(); cpu_req = 1'b0; tick();

    // Deadline: video request lands at the start of a 60-cycle CPU write
    m0 = miss_seen;
    cpu_we = 1; cpu_plane = 0; cpu_addr = 16'h0005; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick();
    serve("dl_cpu", 1'b1, 16'h0005, 4'b0001, 1'b1, 32'h77777777, 60, 32'h0, 0, 16'hBEEF, ic);
    chk("dl_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("dl_cpu_rdata_kept", 32'(cpu_rdata), 32'(exp_rdata));
    cpu_req = 1'b0;
    serve("dl_vid", 1'b0, 16'hBEEF, 4'hF, 1'b0, 32'd0, 3, 32'h5555AAAA, -1, 16'd0, m0);
    exp_miss++; exp_pulses++;
    chk("dl_vid_data", vid_data, 32'h5555AAAA);
    repeat (2) tick();
    chk("dl_miss_pulses", 32'(miss_seen), 32'(exp_pulses));
    chk("dl_miss_cycle", 32'(last_miss_cyc), 32'(ic + 1 + DL));
    chk("dl_miss_count", 32'(miss_count), exp_mc());

    // Randomized mix of fetches and CPU accesses
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_vid("rnd_vid", 16'($urandom), int'($urandom_range(1, 8)), $urandom);
      else
        do_cpu("rnd_cpu", 1'($urandom), 2'($urandom), 16'($urandom), 8'($urandom),
               int'($urandom_range(1, 8)), $urandom, int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (2) tick();
    chk("rnd_miss_pulses", 32'(miss_seen), 32'(exp_pulses));
    chk("rnd_miss_count", 32'(miss_count), exp_mc());

    // Reset in the middle of a video transaction
    vid_addr = 16'h1357; vid_req = 1'b1;
    tick();
    vid_req = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
    chk("rst_mid_vid_data", vid_data, 32'd0);
    exp_miss = 0;
    tick();
    reset_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    tick();
    mem_ack = 1'b0;
    repeat (2) tick();
    chk("rst_late_ack_vid_data", vid_data, 32'd0);
    chk("rst_late_ack_idle", {30'd0, cpu_ack, mem_req}, 32'd0);
    chk("rst_miss_count_clr", 32'(miss_count), exp_mc());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Shares the single 32-bit video memory port (4 planes × 8 bits per word) between the framebuffer's periodic fetch request and CPU byte accesses.
- Sits between the framebuffer's read request/address/vdata interface and the memory controller.
- Video fetches have priority and deadline monitoring; the CPU is served in the gaps through a req/ack handshake.

Parameters:
- VID_DEADLINE, 48: clk24 cycles allowed from a vid_req pulse to video completion before a miss is flagged.
- CNT_W, 8: width of the optional miss counter.

Ports:
- clk24 input 1: system clock, 24 MHz.
- reset_n input 1: reset, asynchronous, active-low.
- vid_req input 1: one-cycle fetch request pulse from the framebuffer.
- vid_addr input 16: word address, sampled with vid_req.
- vid_data output 32: last fetched video word, registered.
- vid_miss output 1: one-cycle pulse when the deadline is exceeded.
- cpu_req input 1: level request, held until cpu_ack.
- cpu_we input 1: 1 = write, 0 = read.
- cpu_addr input 16: word address.
- cpu_plane input 2: plane select, which is also the byte lane select.
- cpu_wdata input 8: write byte.
- cpu_rdata output 8: read byte, registered.
- cpu_ack output 1: one-cycle completion pulse.
- mem_req output 1: request to the memory controller, held until mem_ack.
- mem_we output 1: write strobe qualifier.
- mem_addr output 16: memory word address.
- mem_wdata output 32: write data.
- mem_be output 4: byte enables.
- mem_ack input 1: one-cycle completion pulse from the controller.
- mem_rdata input 32: read data, valid in the mem_ack cycle.
- miss_count output CNT_W: optional, see below.

Behaviour:
- Reset (reset_n low, async):
  - State IDLE.
  - All outputs 0, including vid_data, cpu_rdata and miss_count.
  - Video pending flag, deadline counter and cpu_hold cleared.
  - Any in-flight memory transaction is abandoned; a mem_ack arriving while IDLE is ignored.
- Video capture:
  - vid_req sets vid_pend, latches vid_addr and loads the deadline counter to 0. This happens in any state.
  - vid_req while vid_pend is already set and not yet issued: the address is overwritten, the counter restarts, and vid_miss pulses for the lost fetch.
- Deadline counter:
  - Increments each cycle while vid_pend is set, or while state is VID.
  - Reaching VID_DEADLINE: vid_miss pulses once. The fetch is still completed and vid_data still updates; the counter saturates.
- FSM states: IDLE, VID, CPU.
- IDLE:
  - If vid_pend: go to VID.
  - Else if cpu_req and not cpu_hold: go to CPU.
  - The decision is registered. mem_req and the mem_* fields assert in the first cycle of the new state.
  - Video wins if both requests are present in the same cycle.
- VID:
  - mem_req=1, mem_we=0, mem_addr=latched video address, mem_be=4'hF.
  - On mem_ack: vid_data<=mem_rdata, vid_pend cleared, mem_req deasserts next cycle, go to IDLE.
  - A new vid_req in the mem_ack cycle takes priority over the clear, so vid_pend remains set.
- CPU:
  - mem_req=1, mem_we=cpu_we, mem_addr=cpu_addr.
  - mem_be=1<<cpu_plane; mem_wdata={4{cpu_wdata}}.
  - On mem_ack:
    - cpu_rdata<=mem_rdata[8*cpu_plane+:8] on reads only; writes leave cpu_rdata unchanged.
    - cpu_ack pulses the next cycle; cpu_hold is set; go to IDLE.
  - No preemption: a video request arriving in CPU waits, and the worst-case CPU occupancy counts against VID_DEADLINE.
- cpu_hold clears when cpu_req is sampled low. A held-high cpu_req is never served twice.
- CPU inputs must be stable from cpu_req rise until cpu_ack.
- Latency (controller acks N cycles after mem_req rises):
  - Video: vid_req → vid_data valid in N+2 cycles.
  - CPU, unobstructed: cpu_req → cpu_ack in N+2 cycles.
- mem_req never deasserts before mem_ack, and mem_* fields stay stable while mem_req is high.

Optional Feature:
- Macro: VMEM_ARB_MISS_COUNT_EN.
- When defined: miss_count increments on every vid_miss pulse and saturates at all-ones. It clears only on reset.
- When undefined: miss_count is tied to 0 and no counter logic is generated.

Test Plan:
- Video only: vid_req with vid_addr=16'h80A5, controller acks 3 cycles after mem_req with rdata 32'hDEADBEEF → mem_be=F and mem_we=0; vid_data=32'hDEADBEEF 5 cycles after vid_req; vid_miss stays 0.
- CPU write: cpu_we=1, plane=2, wdata=8'h3C, addr=16'h1234 → mem_be=4'b0100, mem_wdata=32'h3C3C3C3C; one cpu_ack pulse; with cpu_req held high, no second mem_req.
- CPU read: plane=1, mem_rdata=32'h11223344 → cpu_rdata=8'h33 at the cpu_ack pulse.
- Contention: cpu_req and vid_req in the same cycle → video transaction issued first, then CPU; cpu_ack follows vid_data update.
- Deadline: VID_DEADLINE=48, CPU transaction in progress, controller ack delay 60 → vid_miss pulses exactly once, vid_data still updates. With VMEM_ARB_MISS_COUNT_EN defined, miss_count=1.
- Reset mid-transaction: reset_n low while state=VID with mem_req=1 → mem_req=0 immediately; a later mem_ack is ignored; vid_data remains 0.
